// File: rtl/app_output_arbiter_if.sv
// Bundle of every signal exchanged between the output arbiter and the
// application cores / board I/O.
//   master : arbiter side (consumes in_* / app_sel / btn_in, drives outputs)
//   slave  : environment side (application cores, board pins)
// Signals:
//   app_sel    raw application select switches (asynchronous)
//   in_rgb     packed per-channel pixels, channel k at [k*RGB_W +: RGB_W]
//   in_hs/vs   per-channel sync (vsync is an active-low pulse)
//   in_seg/dig per-channel 7-segment segments and digit selects
//   in_beep    per-channel buzzer
//   btn_in     board buttons (already synchronised)
//   btn_out    per-channel buttons, only the active channel sees presses
//   rgb/hs/vs/seg/seg_sel/beep  muxed board outputs
//   active_idx channel currently driving the outputs
//   switching  high while a switch is pending or the display is blanked
interface app_output_arbiter_if #(
  parameter int N_APP = 2,
  parameter int SEL_W = 3,
  parameter int RGB_W = 16,
  parameter int SEG_W = 7,
  parameter int DIG_W = 4,
  parameter int BTN_W = 3
);
  logic [SEL_W-1:0]       app_sel;
  logic [N_APP*RGB_W-1:0] in_rgb;
  logic [N_APP-1:0]       in_hs;
  logic [N_APP-1:0]       in_vs;
  logic [N_APP*SEG_W-1:0] in_seg;
  logic [N_APP*DIG_W-1:0] in_dig;
  logic [N_APP-1:0]       in_beep;
  logic [BTN_W-1:0]       btn_in;
  logic [N_APP*BTN_W-1:0] btn_out;
  logic [RGB_W-1:0]       rgb;
  logic                   hs;
  logic                   vs;
  logic [SEG_W-1:0]       seg;
  logic [DIG_W-1:0]       seg_sel;
  logic                   beep;
  logic [SEL_W-1:0]       active_idx;
  logic                   switching;

  modport master (
    input  app_sel, in_rgb, in_hs, in_vs, in_seg, in_dig, in_beep, btn_in,
    output btn_out, rgb, hs, vs, seg, seg_sel, beep, active_idx, switching
  );

  modport slave (
    output app_sel, in_rgb, in_hs, in_vs, in_seg, in_dig, in_beep, btn_in,
    input  btn_out, rgb, hs, vs, seg, seg_sel, beep, active_idx, switching
  );
endinterface

// File: rtl/app_output_arbiter.sv
// N-application output arbiter: shares one VGA port, one 7-segment display,
// one buzzer and one button bank among N_APP application cores.
// The select switches are synchronised and debounced; a new application is
// taken over only at a vsync falling edge of the running one (or after a
// timeout), then the display is blanked for BLANK_FRAMES frames of the new
// application while its sync signals already reach the monitor.
// Ports:
//   sys_clk  system clock
//   rst      synchronous active-high reset
//   bus      app_output_arbiter_if.master (see interface file for signals)
module app_output_arbiter #(
  parameter int                 N_APP        = 2,
  parameter int                 SEL_W        = 3,
  parameter int                 RGB_W        = 16,
  parameter int                 SEG_W        = 7,
  parameter int                 DIG_W        = 4,
  parameter int                 BTN_W        = 3,
  parameter int                 DEB_CYCLES   = 1000000,
  parameter int                 BLANK_FRAMES = 2,
  parameter int                 PEND_TIMEOUT = 2000000,
  parameter logic [SEG_W-1:0]   SEG_BLANK    = SEG_W'(7'h7F),
  parameter logic [DIG_W-1:0]   DIG_BLANK    = DIG_W'(4'hF)
) (
  input  logic            sys_clk,
  input  logic            rst,
  app_output_arbiter_if.master bus
);

  localparam int DEB_W = (DEB_CYCLES   > 1) ? $clog2(DEB_CYCLES)   : 1;
  localparam int TMO_W = (PEND_TIMEOUT > 1) ? $clog2(PEND_TIMEOUT) : 1;
  localparam int FRM_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PEND_TIMEOUT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLANK_FRAMES - 1);
  localparam logic [SEL_W:0]   NAPP_EXT = (SEL_W + 1)'(N_APP);

  typedef enum logic [1:0] {S_RUN, S_PEND, S_BLANK} state_t;

  // Selects outside the populated channel range mean "no request".
  function automatic logic sel_valid(input logic [SEL_W-1:0] s);
    return ({1'b0, s} < NAPP_EXT);
  endfunction

  logic [SEL_W-1:0] sel_p0, sel_p1;
  logic [DEB_W-1:0] deb_cnt;
  logic [SEL_W-1:0] deb_sel;
  logic [N_APP-1:0] vs_q;
  logic [N_APP-1:0] vs_fall;

  state_t           state, state_n;
  logic [SEL_W-1:0] active, active_n;
  logic [SEL_W-1:0] target, target_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [FRM_W-1:0] frm_cnt, frm_n;
  logic             cur_fall;
  logic             req_ok;
  logic             tmo_last;

  logic [RGB_W-1:0] mux_rgb;
  logic             mux_hs, mux_vs, mux_beep;
  logic [SEG_W-1:0] mux_seg;
  logic [DIG_W-1:0] mux_dig;

  logic [RGB_W-1:0] rgb_p1;
  logic             hs_p1, vs_p1, beep_p1;
  logic [SEG_W-1:0] seg_p1;
  logic [DIG_W-1:0] dig_p1;
  logic [N_APP*BTN_W-1:0] btn_vec;

  // ---- stage p0/p1: select synchroniser, debounce, vsync history ----
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sel_p0  <= '0;
      sel_p1  <= '0;
      deb_cnt <= '0;
      deb_sel <= '0;
      vs_q    <= '1;
    end else begin
      sel_p0 <= bus.app_sel;
      sel_p1 <= sel_p0;
      // sel_p0 != sel_p1 means the synchronised value changes on this edge.
      if (sel_p0 != sel_p1) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_sel <= sel_p1;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
      vs_q <= bus.in_vs;
    end
  end

  assign vs_fall  = vs_q & ~bus.in_vs;
  assign req_ok   = sel_valid(deb_sel);
  assign tmo_last = (tmo_cnt == TMO_LAST);

  always_comb begin
    cur_fall = 1'b0;
    for (int k = 0; k < N_APP; k++) begin
      if (SEL_W'(k) == active) cur_fall = vs_fall[k];
    end
  end

  // ---- switch controller ----
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= S_RUN;
      active  <= '0;
      target  <= '0;
      tmo_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      state   <= state_n;
      active  <= active_n;
      target  <= target_n;
      tmo_cnt <= tmo_n;
      frm_cnt <= frm_n;
    end
  end

  always_comb begin
    state_n  = state;
    active_n = active;
    target_n = target;
    tmo_n    = tmo_cnt;
    frm_n    = frm_cnt;
    case (state)
      S_RUN: begin
        tmo_n = '0;
        frm_n = '0;
        if (req_ok && (deb_sel != active)) begin
          target_n = deb_sel;
          state_n  = S_PEND;
        end
      end
      S_PEND: begin
        tmo_n = tmo_cnt + TMO_W'(1);
        if (req_ok && (deb_sel == active)) begin
          // Request withdrawn back to the running application.
          target_n = deb_sel;
          tmo_n    = '0;
          state_n  = S_RUN;
        end else begin
          if (req_ok && (deb_sel != target)) target_n = deb_sel;
          if (cur_fall || tmo_last) begin
            active_n = target_n;
            tmo_n    = '0;
            frm_n    = '0;
            state_n  = S_BLANK;
          end
        end
      end
      S_BLANK: begin
        // cur_fall already refers to the new application here.
        tmo_n = tmo_cnt + TMO_W'(1);
        if (cur_fall) frm_n = frm_cnt + FRM_W'(1);
        if ((cur_fall && (frm_cnt == FRM_LAST)) || tmo_last) begin
          tmo_n   = '0;
          frm_n   = '0;
          state_n = S_RUN;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  // ---- output mux ----
  always_comb begin
    mux_rgb  = '0;
    mux_hs   = 1'b1;
    mux_vs   = 1'b1;
    mux_seg  = SEG_BLANK;
    mux_dig  = DIG_BLANK;
    mux_beep = 1'b0;
    for (int k = 0; k < N_APP; k++) begin
      if (SEL_W'(k) == active) begin
        mux_rgb  = bus.in_rgb[k*RGB_W +: RGB_W];
        mux_hs   = bus.in_hs[k];
        mux_vs   = bus.in_vs[k];
        mux_seg  = bus.in_seg[k*SEG_W +: SEG_W];
        mux_dig  = bus.in_dig[k*DIG_W +: DIG_W];
        mux_beep = bus.in_beep[k];
      end
    end
  end

  // ---- stage p1: registered board outputs ----
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rgb_p1  <= '0;
      hs_p1   <= 1'b1;
      vs_p1   <= 1'b1;
      seg_p1  <= SEG_BLANK;
      dig_p1  <= DIG_BLANK;
      beep_p1 <= 1'b0;
    end else begin
      // Syncs always follow the active channel so the monitor relocks
      // during blanking.
      hs_p1 <= mux_hs;
      vs_p1 <= mux_vs;
      if (state == S_BLANK) begin
        rgb_p1  <= '0;
        seg_p1  <= SEG_BLANK;
        dig_p1  <= DIG_BLANK;
        beep_p1 <= 1'b0;
      end else begin
        rgb_p1  <= mux_rgb;
        seg_p1  <= mux_seg;
        dig_p1  <= mux_dig;
        beep_p1 <= mux_beep;
      end
    end
  end

  always_comb begin
    btn_vec = '0;
    if (!rst && (state == S_RUN)) begin
      for (int k = 0; k < N_APP; k++) begin
        if (SEL_W'(k) == active) btn_vec[k*BTN_W +: BTN_W] = bus.btn_in;
      end
    end
  end

  assign bus.btn_out    = btn_vec;
  assign bus.rgb        = rgb_p1;
  assign bus.hs         = hs_p1;
  assign bus.vs         = vs_p1;
  assign bus.seg        = seg_p1;
  assign bus.seg_sel    = dig_p1;
  assign bus.beep       = beep_p1;
  assign bus.active_idx = active;
  assign bus.switching  = (state != S_RUN);

endmodule

// File: tb/tb_app_output_arbiter.sv
module tb_app_output_arbiter;

  localparam int N_APP = 3;
  localparam int SEL_W = 3;
  localparam int RGB_W = 16;
  localparam int SEG_W = 7;
  localparam int DIG_W = 4;
  localparam int BTN_W = 3;

  logic sys_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 sys_clk = ~sys_clk;

  app_output_arbiter_if #(
    .N_APP(N_APP), .SEL_W(SEL_W), .RGB_W(RGB_W),
    .SEG_W(SEG_W), .DIG_W(DIG_W), .BTN_W(BTN_W)
  ) ifc ();

  app_output_arbiter #(
    .N_APP(N_APP), .SEL_W(SEL_W), .RGB_W(RGB_W), .SEG_W(SEG_W),
    .DIG_W(DIG_W), .BTN_W(BTN_W), .DEB_CYCLES(4), .BLANK_FRAMES(2),
    .PEND_TIMEOUT(64), .SEG_BLANK(7'h7F), .DIG_BLANK(4'hF)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct {
    logic [47:0] rgb_in;
    logic [2:0]  hs_in;
    logic [2:0]  beep_in;
    logic [20:0] seg_in;
    logic [11:0] dig_in;
    logic [2:0]  btn;
    logic [15:0] e_rgb;
    logic        e_hs;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_beep;
    logic [8:0]  e_btn;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_sw(input logic lvl, input int maxc, output int n);
    n = 0;
    while (ifc.switching !== lvl && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_active_change(input logic [2:0] old, input int maxc, output int n);
    n = 0;
    while (ifc.active_idx === old && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_rows(input int lo, input int hi, input logic [2:0] exp_idx);
    for (int i = lo; i <= hi; i++) begin
      ifc.in_rgb  = vecs[i].rgb_in;
      ifc.in_hs   = vecs[i].hs_in;
      ifc.in_beep = vecs[i].beep_in;
      ifc.in_seg  = vecs[i].seg_in;
      ifc.in_dig  = vecs[i].dig_in;
      ifc.btn_in  = vecs[i].btn;
      tick();
      chk($sformatf("row%0d rgb", i),     ifc.rgb,     vecs[i].e_rgb);
      chk($sformatf("row%0d hs", i),      ifc.hs,      vecs[i].e_hs);
      chk($sformatf("row%0d vs", i),      ifc.vs,      1'b1);
      chk($sformatf("row%0d seg", i),     ifc.seg,     vecs[i].e_seg);
      chk($sformatf("row%0d seg_sel", i), ifc.seg_sel, vecs[i].e_dig);
      chk($sformatf("row%0d beep", i),    ifc.beep,    vecs[i].e_beep);
      chk($sformatf("row%0d btn_out", i), ifc.btn_out, vecs[i].e_btn);
      chk($sformatf("row%0d active", i),  ifc.active_idx, exp_idx);
      chk($sformatf("row%0d switching", i), ifc.switching, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rgb"},       ifc.rgb,        16'h0);
    chk({tag, " hs"},        ifc.hs,         1'b1);
    chk({tag, " vs"},        ifc.vs,         1'b1);
    chk({tag, " seg"},       ifc.seg,        7'h7F);
    chk({tag, " seg_sel"},   ifc.seg_sel,    4'hF);
    chk({tag, " beep"},      ifc.beep,       1'b0);
    chk({tag, " active"},    ifc.active_idx, 3'd0);
    chk({tag, " switching"}, ifc.switching,  1'b0);
  endtask

  initial begin
    int n;

    //            rgb_in (ch2,ch1,ch0)          hs      beep    seg (ch2,ch1,ch0)      dig               btn     e_rgb    hs   seg    dig   beep btn_out
    vecs[0] = '{{16'h2222,16'h1111,16'h0ABC}, 3'b110, 3'b001, {7'h33,7'h22,7'h11}, {4'h3,4'h2,4'h1}, 3'b011, 16'h0ABC, 1'b0, 7'h11, 4'h1, 1'b1, 9'h003};
    vecs[1] = '{{16'h0003,16'hFFFF,16'h8001}, 3'b001, 3'b110, {7'h7F,7'h00,7'h5A}, {4'hF,4'h0,4'hA}, 3'b100, 16'h8001, 1'b1, 7'h5A, 4'hA, 1'b0, 9'h004};
    vecs[2] = '{{16'h0000,16'h0000,16'hFFFF}, 3'b111, 3'b111, {7'h01,7'h02,7'h7F}, {4'h1,4'h2,4'h0}, 3'b111, 16'hFFFF, 1'b1, 7'h7F, 4'h0, 1'b1, 9'h007};
    vecs[3] = '{{16'hFFFF,16'hFFFF,16'h0000}, 3'b000, 3'b000, {7'h7F,7'h7F,7'h00}, {4'hF,4'hF,4'h5}, 3'b000, 16'h0000, 1'b0, 7'h00, 4'h5, 1'b0, 9'h000};
    vecs[4] = '{{16'h2222,16'h1234,16'h0ABC}, 3'b101, 3'b010, {7'h33,7'h44,7'h11}, {4'h3,4'h6,4'h1}, 3'b101, 16'h1234, 1'b0, 7'h44, 4'h6, 1'b1, 9'h028};
    vecs[5] = '{{16'h0000,16'hBEEF,16'h1111}, 3'b010, 3'b101, {7'h00,7'h6B,7'h7F}, {4'h0,4'h9,4'hF}, 3'b101, 16'hBEEF, 1'b1, 7'h6B, 4'h9, 1'b0, 9'h028};
    vecs[6] = '{{16'h0001,16'h8000,16'h0002}, 3'b111, 3'b111, {7'h01,7'h2A,7'h03}, {4'h1,4'hC,4'h3}, 3'b010, 16'h8000, 1'b1, 7'h2A, 4'hC, 1'b1, 9'h010};
    vecs[7] = '{{16'hFFFF,16'h0001,16'hFFFF}, 3'b000, 3'b000, {7'h7F,7'h00,7'h7F}, {4'hF,4'h0,4'hF}, 3'b111, 16'h0001, 1'b0, 7'h00, 4'h0, 1'b0, 9'h038};

    // Reset with busy inputs and a non-zero select.
    rst         = 1'b1;
    ifc.app_sel = 3'd2;
    ifc.in_rgb  = {16'h1111, 16'h2222, 16'h3333};
    ifc.in_hs   = 3'b000;
    ifc.in_vs   = 3'b000;
    ifc.in_seg  = '0;
    ifc.in_dig  = '0;
    ifc.in_beep = 3'b111;
    ifc.btn_in  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_vals($sformatf("rst%0d", i));
      chk($sformatf("rst%0d btn_out", i), ifc.btn_out, 9'h000);
    end
    rst         = 1'b0;
    ifc.app_sel = 3'd0;
    ifc.in_vs   = 3'b111;
    ifc.btn_in  = 3'b000;
    #1;
    chk_reset_vals("release");

    // Channel 0 mirrored with one cycle of latency.
    apply_rows(0, 3, 3'd0);

    // Bouncing select never gets through the debouncer.
    for (int i = 0; i < 40; i++) begin
      ifc.app_sel = ((i / 2) % 2 == 1) ? 3'd1 : 3'd0;
      tick();
      chk($sformatf("bounce%0d switching", i), ifc.switching, 1'b0);
    end
    ifc.app_sel = 3'd0;
    for (int i = 0; i < 8; i++) tick();
    chk("bounce settle switching", ifc.switching, 1'b0);
    chk("bounce settle active", ifc.active_idx, 3'd0);

    // Clean switch 0 -> 1 at a channel-0 frame boundary.
    ifc.in_rgb  = {16'h3333, 16'h5A5A, 16'hC0DE};
    ifc.in_hs   = 3'b101;
    ifc.in_beep = 3'b111;
    ifc.in_seg  = {7'h30, 7'h20, 7'h10};
    ifc.in_dig  = {4'h3, 4'h2, 4'h1};
    ifc.btn_in  = 3'b101;
    ifc.app_sel = 3'd1;
    wait_sw(1'b1, 30, n);
    chk("clean pend latency", n, 7);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("pend%0d switching", i), ifc.switching, 1'b1);
      chk($sformatf("pend%0d active", i), ifc.active_idx, 3'd0);
      chk($sformatf("pend%0d rgb", i), ifc.rgb, 16'hC0DE);
      chk($sformatf("pend%0d hs", i), ifc.hs, 1'b1);
      chk($sformatf("pend%0d btn_out", i), ifc.btn_out, 9'h000);
    end
    ifc.in_vs = 3'b110;
    tick();
    chk("clean blank active", ifc.active_idx, 3'd1);
    chk("clean blank switching", ifc.switching, 1'b1);
    ifc.in_vs = 3'b111;
    tick();
    chk("blank rgb", ifc.rgb, 16'h0);
    chk("blank beep", ifc.beep, 1'b0);
    chk("blank seg", ifc.seg, 7'h7F);
    chk("blank seg_sel", ifc.seg_sel, 4'hF);
    chk("blank hs from ch1", ifc.hs, 1'b0);
    chk("blank btn_out", ifc.btn_out, 9'h000);
    ifc.in_vs = 3'b101;
    tick();
    chk("blank vs from ch1", ifc.vs, 1'b0);
    chk("blank frame1 switching", ifc.switching, 1'b1);
    ifc.in_vs = 3'b111;
    tick();
    chk("blank gap switching", ifc.switching, 1'b1);
    chk("blank gap rgb", ifc.rgb, 16'h0);
    ifc.in_vs = 3'b101;
    tick();
    chk("blank exit switching", ifc.switching, 1'b0);
    chk("blank exit active", ifc.active_idx, 3'd1);
    ifc.in_vs = 3'b111;
    tick();
    chk("run ch1 rgb", ifc.rgb, 16'h5A5A);
    chk("run ch1 seg", ifc.seg, 7'h20);
    chk("run ch1 btn_out", ifc.btn_out, 9'h028);
    apply_rows(4, 7, 3'd1);

    // Invalid select is ignored.
    ifc.app_sel = 3'd5;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("invalid%0d switching", i), ifc.switching, 1'b0);
    end
    chk("invalid active", ifc.active_idx, 3'd1);

    // Request withdrawn during PEND returns to RUN on the same channel.
    ifc.app_sel = 3'd0;
    wait_sw(1'b1, 30, n);
    chk("withdraw pend latency", n, 7);
    ifc.app_sel = 3'd1;
    wait_sw(1'b0, 30, n);
    chk("withdraw run latency", n, 7);
    chk("withdraw active", ifc.active_idx, 3'd1);

    // Retarget 0 -> 2 during PEND; vsync stuck so the timeout fires.
    ifc.app_sel = 3'd0;
    wait_sw(1'b1, 30, n);
    chk("timeout pend latency", n, 7);
    ifc.app_sel = 3'd2;
    wait_active_change(3'd1, 100, n);
    chk("timeout pend cycles", n, 64);
    chk("retarget active", ifc.active_idx, 3'd2);
    chk("timeout blank switching", ifc.switching, 1'b1);
    tick();
    chk("timeout blank rgb", ifc.rgb, 16'h0);
    chk("timeout blank beep", ifc.beep, 1'b0);
    wait_sw(1'b0, 100, n);
    chk("blank timeout cycles", n, 63);
    chk("blank timeout active", ifc.active_idx, 3'd2);

    // Reset during PEND abandons the switch.
    ifc.app_sel = 3'd1;
    wait_sw(1'b1, 30, n);
    chk("midrst pend latency", n, 7);
    tick();
    tick();
    rst         = 1'b1;
    ifc.app_sel = 3'd0;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();
    tick();
    chk("midrst after active", ifc.active_idx, 3'd0);
    chk("midrst after switching", ifc.switching, 1'b0);

    // Select returned to 0 during PEND.
    ifc.app_sel = 3'd1;
    wait_sw(1'b1, 30, n);
    chk("back0 pend latency", n, 7);
    ifc.app_sel = 3'd0;
    wait_sw(1'b0, 30, n);
    chk("back0 run latency", n, 7);
    chk("back0 active", ifc.active_idx, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/app_output_arbiter.md
Name: app_output_arbiter

Overview:
- Parametrised N-application output arbiter for the FPGA game board.
- Shares one VGA port, one 7-segment display, one buzzer and one button bank among N_APP application cores (pong, piano, ...).
- Replaces per-signal combinational muxing with these features:
  - debounced application select;
  - application switching only at a frame boundary;
  - a blanking interval on every switch;
  - buttons routed only to the active application.

Parameters:
- N_APP, 2, number of application channels (2..8).
- SEL_W, 3, width of app_sel.
- RGB_W, 16, pixel bus width per channel.
- SEG_W, 7, segment bus width.
- DIG_W, 4, digit-select bus width.
- BTN_W, 3, button bus width.
- DEB_CYCLES, 1000000, consecutive stable cycles needed to accept a new select value.
- BLANK_FRAMES, 2, number of new-application vsync falling edges spent blanked.
- PEND_TIMEOUT, 2000000, cycles to wait for a frame boundary before forcing the switch.
- SEG_BLANK, 7'h7F, segment value driven while blanked (active-low display).
- DIG_BLANK, 4'hF, digit-select value driven while blanked.

Ports:
- sys_clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- app_sel, in, SEL_W, raw switch select (asynchronous).
- in_rgb, in, N_APP*RGB_W, packed pixels; channel k at bits [k*RGB_W +: RGB_W].
- in_hs, in, N_APP, per-channel hsync.
- in_vs, in, N_APP, per-channel vsync (active-low pulse).
- in_seg, in, N_APP*SEG_W, per-channel segments.
- in_dig, in, N_APP*DIG_W, per-channel digit selects.
- in_beep, in, N_APP, per-channel buzzer.
- btn_in, in, BTN_W, board buttons (already synchronised).
- btn_out, out, N_APP*BTN_W, per-channel buttons.
- rgb, out, RGB_W, muxed pixel.
- hs, out, 1, muxed hsync.
- vs, out, 1, muxed vsync.
- seg, out, SEG_W, muxed segments.
- seg_sel, out, DIG_W, muxed digit select.
- beep, out, 1, muxed buzzer.
- active_idx, out, SEL_W, channel currently driving the outputs.
- switching, out, 1, high in PEND and BLANK.

Behaviour:
- Reset: synchronous, active-high, sampled on the sys_clk rising edge. Values while rst is asserted and on the first cycle after release:
  - FSM in RUN, active_idx=0, target=0, deb_sel=0, all counters=0;
  - rgb=0, hs=1, vs=1, seg=SEG_BLANK, seg_sel=DIG_BLANK, beep=0, btn_out=0, switching=0.
- Reset mid-switch abandons the switch and returns to channel 0.
- Select path:
  - app_sel passes through a 2-FF synchroniser.
  - A stability counter clears whenever the synchronised value changes.
  - When the counter reaches DEB_CYCLES-1 with the value unchanged, deb_sel loads that value on the next edge.
  - Latency from a stable app_sel change to deb_sel update is DEB_CYCLES+2 cycles.
  - deb_sel >= N_APP is treated as no request.
- Outputs are registered: 1-cycle latency from the in_* buses.
- btn_out is combinational: the btn_in slice for active_idx; all other slices are 0. In PEND and BLANK all slices are 0.
- vs edges are detected per channel on a registered copy. Fall = previous 1, current 0.
- FSM:
  - RUN:
    - Drives channel active_idx on every output.
    - On a valid deb_sel != active_idx: target<=deb_sel, go to PEND, clear the timeout counter.
  - PEND:
    - Outputs still follow active_idx; switching=1.
    - If a valid deb_sel changes: target is reloaded. If the new deb_sel equals active_idx: return to RUN.
    - On a vs fall of active_idx, or the timeout counter reaching PEND_TIMEOUT-1: active_idx<=target, clear the frame counter, go to BLANK.
    - If both occur in the same cycle, the transition happens once.
  - BLANK:
    - Outputs: rgb=0, seg=SEG_BLANK, seg_sel=DIG_BLANK, beep=0.
    - hs/vs follow the new active_idx, so the monitor resynchronises.
    - Each vs fall of the new active_idx increments the frame counter. On the BLANK_FRAMES-th fall: go to RUN.
    - deb_sel changes during BLANK are ignored until RUN re-evaluates them.
    - If the new channel has no vsync, BLANK is also exited after PEND_TIMEOUT cycles.
- A held invalid select leaves the current application running indefinitely.

Test Plan:
- All bench cases use N_APP=3, DEB_CYCLES=4, BLANK_FRAMES=2, PEND_TIMEOUT=64.
- Reset: assert rst for 3 cycles with app_sel=2.
  -> rgb=0, hs=vs=1, seg=7'h7F, seg_sel=4'hF, active_idx=0 while rst is high and on the first cycle after release.
  -> From the second cycle after release, outputs mirror channel 0 with 1-cycle latency.
- Bounce: toggle app_sel 0/1 every 2 cycles for 40 cycles, then hold 0.
  -> deb_sel never leaves 0; switching stays 0.
- Clean switch: hold app_sel=1; channel 0 vs falls 20 cycles after deb_sel updates.
  -> PEND for those 20 cycles with channel 0 outputs.
  -> Then BLANK with rgb=0, beep=0 and hs/vs from channel 1.
  -> After channel 1's second vs fall: RUN with active_idx=1 and rgb equal to channel 1 delayed by 1 cycle.
- Timeout: channel 0 vs stuck high, request app 2.
  -> BLANK entered exactly PEND_TIMEOUT cycles after entering PEND.
- Retarget and invalid select:
  -> app_sel 1 then 2 during PEND gives target=2.
  -> app_sel=5 in RUN gives no state change.
  -> app_sel returned to 0 during PEND gives RUN with active_idx=0.
- Buttons: btn_in=3'b101 with active_idx=1 in RUN.
  -> btn_out = {3'b000, 3'b101, 3'b000}.
  -> During BLANK, btn_out=0.
